// File: rtl/mar_burst_if.sv
// Bus-side and RAM-side signals of the burst-capable memory address register.
// The slave modport is the register itself; the master modport is the controller/RAM side.
interface mar_burst_if #(
  parameter int ADDR_W = 4,
  parameter int BUS_W  = 8,
  parameter int LEN_W  = 4
);
  logic              lm;
  logic              inc;
  logic [BUS_W-1:0]  bus;
  logic              burst_start;
  logic [LEN_W-1:0]  burst_len;
  logic              mem_ready;
  logic [ADDR_W-1:0] out_mar;
  logic              mem_valid;
  logic              busy;
  logic              done;

  modport slave (
    input  lm, inc, bus, burst_start, burst_len, mem_ready,
    output out_mar, mem_valid, busy, done
  );

  modport master (
    output lm, inc, bus, burst_start, burst_len, mem_ready,
    input  out_mar, mem_valid, busy, done
  );
endinterface

// File: rtl/mar_burst.sv
// Memory address register with bus load, single-step increment and a
// valid/ready burst walker that presents consecutive addresses to the RAM.
module mar_burst #(
  parameter int ADDR_W = 4,
  parameter int BUS_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mar_burst_if.slave   bif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addrNext;
  logic [LEN_W-1:0]  r_count;
  logic [LEN_W-1:0]  w_countNext;
  logic              r_done;
  logic              w_doneNext;
  logic [ADDR_W-1:0] w_loadVal;

  // A narrow bus is zero-extended, a wide one truncated to the address width.
  generate
    if (BUS_W >= ADDR_W) begin : g_truncate
      assign w_loadVal = bif.bus[ADDR_W-1:0];
    end else begin : g_extend
      assign w_loadVal = {{(ADDR_W-BUS_W){1'b0}}, bif.bus};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_addr  <= w_addrNext;
      r_count <= w_countNext;
      r_done  <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_addrNext  = r_addr;
    w_countNext = r_count;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bif.lm) begin
          w_addrNext = w_loadVal;
        end else if (bif.burst_start) begin
          if (bif.burst_len != '0) begin
            w_countNext = bif.burst_len;
            w_stateNext = BURST;
          end else begin
            w_doneNext = 1'b1;
          end
        end else if (bif.inc) begin
          w_addrNext = r_addr + 1'b1;
        end
      end
      BURST: begin
        // A load aborts the burst and wins over a handshake in the same cycle.
        if (bif.lm) begin
          w_addrNext  = w_loadVal;
          w_countNext = '0;
          w_stateNext = IDLE;
        end else if (bif.mem_ready) begin
          w_addrNext = r_addr + 1'b1;
          if (r_count == LEN_W'(1)) begin
            w_countNext = '0;
            w_stateNext = IDLE;
            w_doneNext  = 1'b1;
          end else begin
            w_countNext = r_count - 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign bif.out_mar   = r_addr;
  assign bif.busy      = (r_state == BURST);
  assign bif.mem_valid = (r_state == BURST);
  assign bif.done      = r_done;

endmodule

// File: doc/mar_burst.md
# mar_burst

Parametrised memory address register for the microcomputer datapath, the successor to the 4-bit load-only MAR. It holds the RAM address and loads it from the shared bus. It also supports single-step increment and an autonomous burst mode that walks consecutive addresses under a valid/ready handshake with the RAM. It sits between the main bus and the RAM address port, driven by the controller's load/increment/burst strobes.

## Interface

Parameters:
- ADDR_W, 4, address register width (≥1)
- BUS_W, 8, width of the main bus
- LEN_W, 4, width of burst_len; the maximum burst is 2^LEN_W − 1 words

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- lm  input  1  load address from bus
- inc  input  1  increment address by one
- bus  input  BUS_W  main bus
- burst_start  input  1  request a burst starting at the current address
- burst_len  input  LEN_W  number of words in the burst; sampled with burst_start
- mem_ready  input  1  RAM accepts the current address this cycle
- out_mar  output  ADDR_W  current address, registered
- mem_valid  output  1  out_mar is a burst address awaiting acceptance
- busy  output  1  burst in progress (state BURST)
- done  output  1  one-cycle pulse marking burst completion

## Operation

- Clock/reset: one clock, clk. Reset is synchronous and active-low, on rst_n.
- Reset values, applied at the first rising edge with rst_n=0 (also mid-burst, with no done pulse):
  - out_mar=0, mem_valid=0, busy=0, done=0
  - state IDLE, remaining count 0
- Load width rule:
  - Loaded value is bus[ADDR_W-1:0] when BUS_W ≥ ADDR_W.
  - Otherwise bus is zero-extended.
- Arithmetic: all address arithmetic is modulo 2^ADDR_W, so all-ones + 1 wraps to 0.
- States: IDLE, BURST, plus a registered done flag.
- IDLE, actions by priority (highest first):
  - lm=1: out_mar ← bus value.
  - burst_start=1 with burst_len≠0: latch count ← burst_len, go to BURST, mem_valid ← 1. out_mar is unchanged and is the first burst address.
  - burst_start=1 with burst_len=0: no transfer, stay IDLE, done=1 next cycle.
  - inc=1: out_mar ← out_mar+1.
  - otherwise: hold.
- BURST:
  - Handshake occurs in any cycle with mem_valid=1 and mem_ready=1.
  - On a handshake with count>1: out_mar ← out_mar+1, count ← count−1, remain in BURST.
  - On a handshake with count=1: out_mar ← out_mar+1, go to IDLE, mem_valid ← 0, done ← 1.
  - mem_ready=0: hold address and count. mem_valid stays high; it is never withdrawn before acceptance.
  - lm=1 aborts the burst: out_mar ← bus value, go to IDLE, mem_valid ← 0, no done pulse. lm takes priority over a simultaneous handshake.
  - inc and burst_start are ignored.
- Final address after a full burst is base+burst_len (mod 2^ADDR_W).
- done is high for exactly one cycle, then clears automatically.

## Timing

- Load and increment latency: one cycle; out_mar shows the new value after the edge that samples the strobe.
- Burst start: mem_valid and busy rise one cycle after burst_start is sampled.
- Throughput: with mem_ready held high, one address per cycle; a burst of N takes N cycles in BURST.
- Completion: done is high in the cycle after the final handshake. busy and mem_valid are low in that same cycle.
- A new burst_start is accepted in the cycle done is high, because the block is already IDLE.
- busy = (state==BURST), and mem_valid equals busy.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset/load: hold rst_n=0 for 2 cycles → all outputs 0. Then lm=1, bus=8'hA7 with ADDR_W=4 → out_mar=4'h7 next cycle.
- Increment wrap: load 4'hE, pulse inc twice → out_mar 4'hF then 4'h0.
- Full burst: load 4'h3, burst_start with burst_len=4, mem_ready=1.
  - Required: mem_valid high for 4 cycles with out_mar 3,4,5,6.
  - Then done=1 for one cycle with out_mar=7 and busy=0.
- Backpressure plus wrap: load 4'hF, burst_len=2, mem_ready toggling 0,1,0,0,1.
  - Required: out_mar holds F until the first handshake, then 0, then ends at 1 with done after the second handshake.
  - mem_valid never drops early.
- Abort and reset mid-burst, each in a separate burst with burst_len=5:
  - Assert lm with bus=8'h09 in the 2nd burst cycle → IDLE, out_mar=9, no done.
  - In another burst, drive rst_n=0 mid-burst → out_mar=0, busy=0, no done.
- Zero length: burst_start with burst_len=0 → mem_valid never rises, done=1 the next cycle, out_mar unchanged.
